// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory load/store interface.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_type_t;

  localparam logic [1:0] MEM_RSVD = 2'b11;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_RESP
  } rsp_state_t;

  function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] off);
    if (typ == MEM_HALF) return off[0];
    if (typ == MEM_WORD) return off != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// Lane extraction and sign/zero extension of a little-endian RAM word.
module load_extend
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            off_i,
  input  logic [1:0]            type_i,
  input  logic                  sign_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (type_i)
      MEM_BYTE: data_o = {{(DATA_WIDTH-8){sign_i & byte_sel[7]}}, byte_sel};
      MEM_HALF: data_o = {{(DATA_WIDTH-16){sign_i & half_sel[15]}}, half_sel};
      default:  data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, fixed wait states,
// byte-lane stores, extended loads and access-error reporting.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);

  rsp_state_t            state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            type_q;
  logic                  sign_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  acc_go;
  logic                  acc_err_d;
  logic                  wr_en;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [DATA_WIDTH-1:0] rdata_d;

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .word_i (mem_q[word_idx]),
    .off_i  (addr_q[1:0]),
    .type_i (type_q),
    .sign_i (sign_q),
    .data_o (ext_data)
  );

  always_comb begin
    word_idx   = addr_q[ADDR_WIDTH-1:2];
    acc_go     = (state_q == RSP_WAIT) && (cnt_q == '0);
    acc_err_d  = (type_q == MEM_RSVD) || is_misaligned(type_q, addr_q[1:0]) ||
                 (|addr_q[DATA_WIDTH-1:ADDR_WIDTH]);
    be         = '0;
    wdata_lane = wdata_q;
    case (type_q)
      MEM_BYTE: begin
        be[addr_q[1:0]] = 1'b1;
        wdata_lane      = {4{wdata_q[7:0]}};
      end
      MEM_HALF: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      MEM_WORD: be = 4'b1111;
      default:  be = '0;
    endcase
    wr_en   = acc_go && we_q && !acc_err_d;
    rdata_d = (we_q || acc_err_d) ? '0 : ext_data;
  end

  // Array has no reset; an async reset in WAIT leaves state_q idle so wr_en never fires.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RSP_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      type_q      <= '0;
      sign_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        RSP_IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            type_q      <= req_type_i;
            sign_q      <= req_sign_i;
            cnt_q       <= 4'(WAIT_STATES);
            req_ready_q <= 1'b0;
            state_q     <= RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= acc_err_d;
            state_q     <= RSP_RESP;
          end
        end
        RSP_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= RSP_IDLE;
          end
        end
        default: begin
          state_q     <= RSP_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

  localparam int unsigned WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i, req_sign_i, rsp_ready_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_type_i;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;

  logic        req_valid0, req_we0, req_sign0, rsp_ready0;
  logic [31:0] req_addr0, req_wdata0;
  logic [1:0]  req_type0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_type_i(req_type_i),
    .req_sign_i(req_sign_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we0),
    .req_addr_i(req_addr0), .req_wdata_i(req_wdata0), .req_type_i(req_type0),
    .req_sign_i(req_sign0), .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem [4096];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit          hold = 1'b0;
  bit          prev_valid = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  // Reference: byte-addressed memory, rules applied directly to the address.
  task automatic ref_exec(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] typ, input logic sgn,
                          output logic [31:0] rd, output logic err);
    int unsigned a;
    a   = addr;
    err = (typ == 2'b11) || (typ == 2'b01 && addr[0]) ||
          (typ == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'h1000);
    rd  = '0;
    if (err) return;
    if (we) begin
      ref_mem[a] = wd[7:0];
      if (typ != 2'b00) ref_mem[a+1] = wd[15:8];
      if (typ == 2'b10) begin
        ref_mem[a+2] = wd[23:16];
        ref_mem[a+3] = wd[31:24];
      end
    end else begin
      case (typ)
        2'b00: rd = {{24{sgn & ref_mem[a][7]}}, ref_mem[a]};
        2'b01: rd = {{16{sgn & ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
        default: rd = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      endcase
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] typ, input logic sgn, input bit push);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_type_i  = typ;
    req_sign_i  = sgn;
    guard = 0;
    while (!req_ready_o) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        n_checks++;
        $display("FAIL accept_timeout: actual ready=%b required ready=1", req_ready_o);
        req_valid_i = 1'b0;
        return;
      end
    end
    e.acc = cyc + 1;
    if (push) begin
      ref_exec(we, addr, wd, typ, sgn, e.rdata, e.err);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_type_i  = 2'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 || rsp_valid_o) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        n_checks++;
        $display("FAIL drain_timeout: actual pending=%0d required pending=0", sbq.size());
        return;
      end
    end
  endtask

  initial begin
    rsp_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      rsp_ready_i = hold ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_valid = 1'b0;
      end else begin
        if (rsp_valid_o && !prev_valid) begin
          if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: actual valid=1 required valid=0");
          end else begin
            cur = sbq.pop_front();
            chk("rsp_rdata", rsp_rdata_o, cur.rdata);
            chk("rsp_err", 32'(rsp_err_o), 32'(cur.err));
            chk("latency", cyc - cur.acc, WS + 1);
          end
          held_rdata = rsp_rdata_o;
          held_err   = rsp_err_o;
        end else if (rsp_valid_o) begin
          chk("hold_rdata", rsp_rdata_o, held_rdata);
          chk("hold_err", 32'(rsp_err_o), 32'(held_err));
        end
        if (rsp_valid_o) chk("ready_in_resp", 32'(req_ready_o), 32'd0);
        prev_valid = rsp_valid_o;
      end
    end
  end

  initial begin
    int guard;
    logic [1:0]  typ;
    logic [31:0] addr;
    rst = 1'b1;
    {req_valid_i, req_we_i, req_sign_i} = '0;
    req_addr_i = '0; req_wdata_i = '0; req_type_i = '0;
    {req_valid0, req_we0, req_sign0} = '0;
    req_addr0 = '0; req_wdata0 = '0; req_type0 = '0;
    rsp_ready0 = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    #10 rst = 1'b1;

    for (int unsigned i = 0; i < 1024; i++) do_req(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, 1'b1);

    do_req(1'b1, 32'h010, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1);
    do_req(1'b1, 32'h013, 32'h00000080, 2'b00, 1'b0, 1'b1);
    do_req(1'b0, 32'h013, 32'h0, 2'b00, 1'b1, 1'b1);
    do_req(1'b0, 32'h013, 32'h0, 2'b00, 1'b0, 1'b1);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1);
    do_req(1'b0, 32'h012, 32'h0, 2'b01, 1'b1, 1'b1);

    do_req(1'b1, 32'h011, 32'h0000FFFF, 2'b01, 1'b0, 1'b1);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1);
    do_req(1'b0, 32'h012, 32'h0, 2'b10, 1'b0, 1'b1);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1);
    do_req(1'b1, 32'h010, 32'h00000000, 2'b11, 1'b0, 1'b1);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1);
    do_req(1'b1, 32'h1010, 32'h00000000, 2'b10, 1'b0, 1'b1);
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1);

    drain();
    hold = 1'b1;
    do_req(1'b0, 32'h013, 32'h0, 2'b00, 1'b1, 1'b1);
    guard = 0;
    while (!rsp_valid_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid", 32'(rsp_valid_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", 32'(req_ready_o), 32'd0);
      req_valid_i = (k == 0);
      req_we_i = 1'b1; req_addr_i = 32'h010; req_wdata_i = 32'h0; req_type_i = 2'b10;
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    hold = 1'b0;
    do_req(1'b0, 32'h010, 32'h0, 2'b10, 1'b0, 1'b1);

    drain();
    do_req(1'b1, 32'h020, 32'h12345678, 2'b10, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready_o), 32'd1);
    chk("midrst_valid", 32'(rsp_valid_o), 32'd0);
    chk("midrst_rdata", rsp_rdata_o, 32'd0);
    chk("midrst_err", 32'(rsp_err_o), 32'd0);
    #1 rst = 1'b1;
    do_req(1'b0, 32'h020, 32'h0, 2'b10, 1'b0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      typ  = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
      addr = 32'($urandom_range(4095));
      if ($urandom_range(3) != 0) begin
        if (typ == 2'b01) addr[0] = 1'b0;
        if (typ == 2'b10) addr[1:0] = 2'b00;
      end
      if ($urandom_range(19) == 0) addr = $urandom | 32'h1000;
      do_req(1'($urandom), addr, $urandom, typ, 1'($urandom), 1'b1);
    end
    drain();

    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h040;
    req_wdata0 = 32'hCAFEF00D; req_type0 = 2'b10;
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("ws0_st_early", 32'(rsp_valid0), 32'd0);
    @(negedge clk);
    chk("ws0_st_valid", 32'(rsp_valid0), 32'd1);
    chk("ws0_st_rdata", rsp_rdata0, 32'd0);
    chk("ws0_st_err", 32'(rsp_err0), 32'd0);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h040; req_type0 = 2'b10;
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("ws0_ld_early", 32'(rsp_valid0), 32'd0);
    @(negedge clk);
    chk("ws0_ld_valid", 32'(rsp_valid0), 32'd1);
    chk("ws0_ld_rdata", rsp_rdata0, 32'hCAFEF00D);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
